// File: rtl/mult_selftest.sv
// mult_selftest: built-in self test for an external WIDTH x WIDTH unsigned multiplier.
// Operands come from a 16-bit Fibonacci LFSR. The reference product is formed by a
// local shift-add engine, and each returned product is checked against it.
// Optional feature macro: MULT_SELFTEST_FAIL_CAPTURE_EN keeps the first failing vector
// (operands and product) on fail_a/fail_b/fail_prod. Without the macro these outputs
// are tied to zero.
//
// state | meaning
// IDLE  | waiting for start after reset
// DRIVE | present operands for one cycle and step the LFSR
// WAIT  | run the shift-add; collect the product or time out
// CHECK | compare, update the counters, pick the next vector or finish
// DONE  | results held until the next start
module mult_selftest #(
  parameter int          WIDTH       = 8,
  parameter int          NUM_VECTORS = 64,
  parameter int          TIMEOUT     = 32,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 sys_clock,
  input  logic                 reset_rtl,
  input  logic                 start,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  output logic                 op_valid,
  input  logic [2*WIDTH-1:0]   prod_in,
  input  logic                 prod_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           err_count,
  output logic [7:0]           vec_count,
  output logic [WIDTH-1:0]     fail_a,
  output logic [WIDTH-1:0]     fail_b,
  output logic [2*WIDTH-1:0]   fail_prod
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [15:0]          lfsr_q;
  logic [15:0]          lfsr_step;
  logic [WIDTH-1:0]     op_a_q, op_b_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CW-1:0]        bit_cnt_q;
  logic [TW-1:0]        tmo_cnt_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic                 prod_got_q;
  logic                 tmo_q;
  logic [7:0]           err_q, vec_q;
  logic [7:0]           vec_next;
  logic                 prod_ok, mul_ready, tmo_last, leave_tmo, mismatch, start_ok;

  assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign prod_ok   = prod_got_q | prod_valid;
  // mul_ready is true while the last shift-add step is in progress, so CHECK
  // sees the final accumulator value one cycle later.
  assign mul_ready = (bit_cnt_q <= CW'(1));
  assign tmo_last  = (tmo_cnt_q <= TW'(1));
  assign leave_tmo = (state_q == S_WAIT) && tmo_last && !prod_ok;
  assign mismatch  = tmo_q || (prod_q != acc_q);
  assign vec_next  = vec_q + 8'd1;
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign op_valid  = (state_q == S_DRIVE);
  assign busy      = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = (state_q == S_DONE) && (err_q == 8'd0);
  assign err_count = err_q;
  assign vec_count = vec_q;

  // State register.
  always_ff @(posedge sys_clock or posedge reset_rtl) begin
    if (reset_rtl) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_DRIVE;
      S_DRIVE:        state_d = S_WAIT;
      S_WAIT: begin
        if (mul_ready && prod_ok) state_d = S_CHECK;
        else if (leave_tmo)       state_d = S_CHECK;
      end
      S_CHECK: begin
        if ({1'b0, vec_next} < 9'(NUM_VECTORS)) state_d = S_DRIVE;
        else                                     state_d = S_DONE;
      end
      default:        state_d = S_IDLE;
    endcase
  end

  // Operand generation, reference shift-add, product capture and result counters.
  always_ff @(posedge sys_clock or posedge reset_rtl) begin
    if (reset_rtl) begin
      lfsr_q     <= LFSR_SEED;
      op_a_q     <= '0;
      op_b_q     <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      bit_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      prod_q     <= '0;
      prod_got_q <= 1'b0;
      tmo_q      <= 1'b0;
      err_q      <= '0;
      vec_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            lfsr_q <= LFSR_SEED;
            op_a_q <= LFSR_SEED[WIDTH-1:0];
            op_b_q <= LFSR_SEED[15 -: WIDTH];
            err_q  <= '0;
            vec_q  <= '0;
          end
        end
        S_DRIVE: begin
          lfsr_q     <= lfsr_step;
          mcand_q    <= {{WIDTH{1'b0}}, op_a_q};
          mplier_q   <= op_b_q;
          acc_q      <= '0;
          bit_cnt_q  <= CW'(WIDTH);
          tmo_cnt_q  <= TW'(TIMEOUT);
          prod_q     <= '0;
          prod_got_q <= 1'b0;
          tmo_q      <= 1'b0;
        end
        S_WAIT: begin
          if (bit_cnt_q != '0) begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q   <= mcand_q << 1;
            mplier_q  <= mplier_q >> 1;
            bit_cnt_q <= bit_cnt_q - CW'(1);
          end
          if (tmo_cnt_q != '0) tmo_cnt_q <= tmo_cnt_q - TW'(1);
          if (prod_valid && !prod_got_q) begin
            prod_q     <= prod_in;
            prod_got_q <= 1'b1;
          end
          if (leave_tmo) tmo_q <= 1'b1;
        end
        S_CHECK: begin
          vec_q <= vec_next;
          if (mismatch && (err_q != 8'hFF)) err_q <= err_q + 8'd1;
          if (state_d == S_DRIVE) begin
            op_a_q <= lfsr_q[WIDTH-1:0];
            op_b_q <= lfsr_q[15 -: WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULT_SELFTEST_FAIL_CAPTURE_EN
  logic [WIDTH-1:0]   fail_a_q, fail_b_q;
  logic [2*WIDTH-1:0] fail_prod_q;

  // First failing vector of the run; prod_q is already zero after a timeout.
  always_ff @(posedge sys_clock or posedge reset_rtl) begin
    if (reset_rtl) begin
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      fail_prod_q <= '0;
    end else if (start_ok) begin
      fail_a_q    <= '0;
      fail_b_q    <= '0;
      fail_prod_q <= '0;
    end else if ((state_q == S_CHECK) && mismatch && (err_q == 8'd0)) begin
      fail_a_q    <= op_a_q;
      fail_b_q    <= op_b_q;
      fail_prod_q <= prod_q;
    end
  end

  assign fail_a    = fail_a_q;
  assign fail_b    = fail_b_q;
  assign fail_prod = fail_prod_q;
`else
  assign fail_a    = '0;
  assign fail_b    = '0;
  assign fail_prod = '0;
`endif

endmodule

// File: tb/tb_mult_selftest.sv
// Directed bench for mult_selftest: a behavioural multiplier with a programmable
// latency and an optional fault on vector 5, driven through one linear sequence.
`timescale 1ns/1ps
module tb_mult_selftest;

  logic        sys_clock = 1'b0;
  logic        reset_rtl;
  logic        start;
  logic [7:0]  op_a, op_b;
  logic        op_valid;
  logic [15:0] prod_in;
  logic        prod_valid;
  logic        busy, done, pass;
  logic [7:0]  err_count, vec_count;
  logic [7:0]  fail_a, fail_b;
  logic [15:0] fail_prod;

  int n_cmp = 0;
  int n_err = 0;

  // model controls (set by the stimulus)
  int          lat = 3;          // 0 = never answer
  logic        corrupt = 1'b0;   // a*b+1 on the 5th vector
  logic        stray_pv = 1'b0;
  logic [15:0] stray_prod = '0;

  // model state
  logic        model_pv = 1'b0;
  logic [15:0] model_prod = '0;
  logic [15:0] pend_prod = '0;
  int          pcnt = 0;
  int          nvec = 0;
  int          cyc = 0;
  int          t_first = 0;
  int          gap12 = 0;
  logic [7:0]  log_a [0:7];
  logic [7:0]  log_b [0:7];

  assign prod_valid = model_pv | stray_pv;
  assign prod_in    = stray_pv ? stray_prod : model_prod;

  mult_selftest dut (
    .sys_clock (sys_clock),
    .reset_rtl (reset_rtl),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_valid  (op_valid),
    .prod_in   (prod_in),
    .prod_valid(prod_valid),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .vec_count (vec_count),
    .fail_a    (fail_a),
    .fail_b    (fail_b),
    .fail_prod (fail_prod)
  );

  always #5 sys_clock = ~sys_clock;

  // Behavioural multiplier plus operand log and op_valid spacing measurement.
  always @(posedge sys_clock) begin
    logic [15:0] p;
    cyc      <= cyc + 1;
    model_pv <= 1'b0;
    if (reset_rtl || (start && !busy)) begin
      pcnt <= 0;
      nvec <= 0;
    end else if (op_valid) begin
      nvec <= nvec + 1;
      if (nvec < 8) begin
        log_a[nvec] <= op_a;
        log_b[nvec] <= op_b;
      end
      if (nvec == 0) t_first <= cyc;
      if (nvec == 1) gap12 <= cyc - t_first;
      p = 16'(op_a) * 16'(op_b);
      if (corrupt && nvec == 4) p = p + 16'd1;
      if (lat == 1) begin
        model_pv   <= 1'b1;
        model_prod <= p;
      end else if (lat > 1) begin
        pcnt      <= lat - 1;
        pend_prod <= p;
      end
    end else if (pcnt != 0) begin
      pcnt <= pcnt - 1;
      if (pcnt == 1) begin
        model_pv   <= 1'b1;
        model_prod <= pend_prod;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns at the negedge of the first DRIVE cycle.
  task automatic pulse_start();
    @(negedge sys_clock);
    start = 1'b1;
    @(negedge sys_clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge sys_clock);
      k++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int k;
    reset_rtl = 1'b1;
    start     = 1'b0;

    // reset state
    #3;
    check("rst_ctrl", {4'd0, op_a, op_b, op_valid, busy, done, pass, err_count, vec_count}, 32'd0);
    check("rst_fail", {fail_a, fail_b, fail_prod}, 32'd0);
    repeat (2) @(negedge sys_clock);
    reset_rtl = 1'b0;

    // stray product while idle must be ignored
    @(negedge sys_clock);
    stray_pv = 1'b1; stray_prod = 16'hDEAD;
    @(negedge sys_clock);
    stray_pv = 1'b0;
    check("idle_stray", {29'd0, busy, done, pass}, 32'd0);

    // ideal multiplier, 3-cycle latency
    lat = 3; corrupt = 1'b0;
    pulse_start();
    check("drive_strobe", {30'd0, op_valid, busy}, 32'd3);
    check("first_ops", {16'd0, op_a, op_b}, 32'h0000_E1AC);
    check("pass_low_busy", {31'd0, pass}, 32'd0);
    wait_done("ideal_done", 2000);
    check("ideal_pass", {31'd0, pass}, 32'd1);
    check("ideal_counts", {16'd0, err_count, vec_count}, 32'h0000_0040);
    check("ideal_busy", {31'd0, busy}, 32'd0);
    check("ideal_gap", gap12, 32'd10);
    check("lfsr_v2", {16'd0, log_a[1], log_b[1]}, 32'h0000_C359);
    check("lfsr_v3", {16'd0, log_a[2], log_b[2]}, 32'h0000_87B3);
    check("lfsr_v4", {16'd0, log_a[3], log_b[3]}, 32'h0000_0F67);
    check("lfsr_v5", {16'd0, log_a[4], log_b[4]}, 32'h0000_1ECE);

    // product arriving before the shift-add finishes
    lat = 1;
    pulse_start();
    check("restart_clears_done", {31'd0, done}, 32'd0);
    wait_done("early_done", 2000);
    check("early_pass", {24'd0, pass, 7'd0}, 32'h0000_0080);
    check("early_counts", {16'd0, err_count, vec_count}, 32'h0000_0040);
    check("early_gap", gap12, 32'd10);

    // product arriving after the shift-add finishes
    lat = 12;
    pulse_start();
    wait_done("late_done", 3000);
    check("late_pass", {31'd0, pass}, 32'd1);
    check("late_gap", gap12, 32'd14);

    // faulty 5th product, with an ignored start while busy
    lat = 3; corrupt = 1'b1;
    pulse_start();
    repeat (25) @(negedge sys_clock);
    check("busy_mid", {31'd0, busy}, 32'd1);
    start = 1'b1;
    @(negedge sys_clock);
    start = 1'b0;
    wait_done("corrupt_done", 2000);
    check("corrupt_pass", {31'd0, pass}, 32'd0);
    check("corrupt_counts", {16'd0, err_count, vec_count}, 32'h0000_0140);
    check("corrupt_seq_v5", {16'd0, log_a[4], log_b[4]}, 32'h0000_1ECE);
`ifdef MULT_SELFTEST_FAIL_CAPTURE_EN
    check("corrupt_fail_ops", {16'd0, fail_a, fail_b}, 32'h0000_1ECE);
    check("corrupt_fail_prod", {16'd0, fail_prod}, 32'h0000_1825);
`else
    check("corrupt_fail_tied", {fail_a, fail_b, fail_prod}, 32'd0);
`endif

    // multiplier never answers: every vector times out
    lat = 0; corrupt = 1'b0;
    pulse_start();
    wait_done("tmo_done", 5000);
    check("tmo_pass", {31'd0, pass}, 32'd0);
    check("tmo_counts", {16'd0, err_count, vec_count}, 32'h0000_4040);
    check("tmo_gap", gap12, 32'd34);
`ifdef MULT_SELFTEST_FAIL_CAPTURE_EN
    check("tmo_fail", {fail_a, fail_b, fail_prod}, 32'hE1AC_0000);
`else
    check("tmo_fail_tied", {fail_a, fail_b, fail_prod}, 32'd0);
`endif

    // reset during vector 10, then a fresh run
    lat = 3;
    pulse_start();
    k = 0;
    while (nvec < 10 && k < 300) begin
      @(negedge sys_clock);
      k++;
    end
    check("reach_v10", {31'd0, (nvec >= 10)}, 32'd1);
    #2 reset_rtl = 1'b1;
    #1;
    check("midrun_rst_ctrl", {4'd0, op_a, op_b, op_valid, busy, done, pass, err_count, vec_count}, 32'd0);
    check("midrun_rst_fail", {fail_a, fail_b, fail_prod}, 32'd0);
    @(negedge sys_clock);
    reset_rtl = 1'b0;
    repeat (20) @(negedge sys_clock);
    check("no_done_after_rst", {30'd0, busy, done}, 32'd0);
    pulse_start();
    check("fresh_first_ops", {16'd0, op_a, op_b}, 32'h0000_E1AC);
    wait_done("fresh_done", 2000);
    check("fresh_pass", {31'd0, pass}, 32'd1);
    check("fresh_v2", {16'd0, log_a[1], log_b[1]}, 32'h0000_C359);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
